unified_mem_arbiter: RTL and testbench

- Sequences the single unified memory port of the multicycle core.
- Arbitrates between the instruction-fetch requester and the load/store requester; this replaces ad-hoc IorD muxing at the memory.
- Holds address, write data and control stable for a fixed access latency, captures read data, and returns a one-cycle ready pulse to the winning requester.
- Data accesses win by default. A streak limit prevents fetch starvation.

---
 rtl/unified_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Unified memory port sequencer for the multicycle core.
// Arbitrates fetch vs. load/store, holds the selected access on the memory
// port for MEM_LAT cycles, captures read data and pulses the winner's ready.
// Data wins by default; a streak limit guarantees fetch eventually gets in.
//
// state  | meaning
// IDLE   | no access in flight, requests are sampled and arbitrated
// ACCESS | strobes held on the memory port, cnt counts down to the last cycle
// DONE   | strobes dropped, ready pulsed to the owner of the access
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 3,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_D_STREAK);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_fetch;

  // Next-state logic: arbitration in IDLE, countdown and capture in ACCESS.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    grant_d    = grant_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Fetch only preempts a pending data request once the streak is full.
          pick_fetch = if_req && (!d_req || (streak_q == STK_MAX));
          grant_d    = ~pick_fetch;
          addr_d     = pick_fetch ? if_addr : d_addr;
          wdata_d    = pick_fetch ? wdata_q : d_wdata;
          we_d       = pick_fetch ? 1'b0 : d_we;
          if (!pick_fetch && if_req) begin
            streak_d = (streak_q == STK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (grant_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      grant_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      grant_q    <= grant_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Strobes and ready pulses decode straight from state so reset drops them at once.
  always_comb begin
    mem_read  = (state_q == ACCESS) && !we_q;
    mem_write = (state_q == ACCESS) && we_q;
    if_ready  = (state_q == DONE) && !grant_q;
    d_ready   = (state_q == DONE) && grant_q;
    busy      = (state_q != IDLE);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    grant_id  = grant_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int L    = 3;
  localparam int MAXS = 2;

  logic        clk, reset_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_read, mem_write, busy, grant_id;

  logic        l1_if_req, l1_d_req, l1_d_we;
  logic [31:0] l1_if_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l1_if_ready, l1_d_ready, l1_mem_read, l1_mem_write, l1_busy, l1_grant_id;

  int total;
  int bad;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .MAX_D_STREAK(MAXS)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
    .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata),
    .busy(l1_busy), .grant_id(l1_grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_d_req = 0; l1_d_we = 0; l1_d_addr = 0;
    l1_d_wdata = 0; l1_mem_rdata = 0;
    #12;
    total++; if ({if_rdata, d_rdata} !== 64'h0) begin bad++;
      $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++;
      $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    total++; if ({mem_read, mem_write, if_ready, d_ready} !== 4'b0) begin bad++;
      $display("FAIL reset_strobes got=%b exp=0000", {mem_read, mem_write, if_ready, d_ready}); end
    total++; if ({busy, grant_id, l1_busy, l1_mem_read} !== 4'b0) begin bad++;
      $display("FAIL reset_busy_gid got=%b exp=0000", {busy, grant_id, l1_busy, l1_mem_read}); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h10; mem_rdata = 0;
    for (int k = 1; k <= L; k++) begin
      tick();
      if (k == L) mem_rdata = 32'hDEADBEEF;
      total++; if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin bad++;
        $display("FAIL fetch_access%0d got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=10", k, mem_read, mem_write, mem_addr); end
    end
    tick();
    mem_rdata = 0;
    total++; if ({if_ready, d_ready, grant_id, mem_read} !== 4'b1000) begin bad++;
      $display("FAIL fetch_ready got ifr=%b dr=%b gid=%b rd=%b exp 1 0 0 0", if_ready, d_ready, grant_id, mem_read); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
    if_req = 0;
    tick();
    total++; if ({if_ready, busy} !== 2'b00) begin bad++;
      $display("FAIL fetch_after got ifr=%b busy=%b exp 0 0", if_ready, busy); end
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int k = 1; k <= L; k++) begin
      tick();
      if (k == L) mem_rdata = 32'hA5A50001;
      total++; if ({mem_read, mem_write, mem_addr, grant_id} !== {1'b1, 1'b0, 32'h200, 1'b1}) begin bad++;
        $display("FAIL cont_data%0d got rd=%b wr=%b addr=%h gid=%b exp 1 0 200 1", k, mem_read, mem_write, mem_addr, grant_id); end
    end
    tick();
    mem_rdata = 0;
    total++; if ({d_ready, if_ready} !== 2'b10) begin bad++;
      $display("FAIL cont_dready got dr=%b ifr=%b exp 1 0", d_ready, if_ready); end
    total++; if ({d_rdata, if_rdata} !== {32'hA5A50001, 32'hDEADBEEF}) begin bad++;
      $display("FAIL cont_drdata got d=%h if=%h exp a5a50001 deadbeef", d_rdata, if_rdata); end
    d_req = 0;
    tick();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL cont_idle got busy=%b exp 0", busy); end
    for (int k = 1; k <= L; k++) begin
      tick();
      if (k == L) mem_rdata = 32'h0BADF00D;
      total++; if ({mem_read, mem_addr, grant_id} !== {1'b1, 32'h300, 1'b0}) begin bad++;
        $display("FAIL cont_fetch%0d got rd=%b addr=%h gid=%b exp 1 300 0", k, mem_read, mem_addr, grant_id); end
    end
    tick();
    mem_rdata = 0;
    total++; if ({d_ready, if_ready} !== 2'b01) begin bad++;
      $display("FAIL cont_ifready got dr=%b ifr=%b exp 0 1", d_ready, if_ready); end
    total++; if ({if_rdata, d_rdata} !== {32'h0BADF00D, 32'hA5A50001}) begin bad++;
      $display("FAIL cont_ifrdata got if=%h d=%h exp 0badf00d a5a50001", if_rdata, d_rdata); end
    if_req = 0;
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; mem_rdata = 32'hFFFFFFFF;
    for (int k = 1; k <= L; k++) begin
      tick();
      total++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h40, 32'h12345678}) begin bad++;
        $display("FAIL store_access%0d got rd=%b wr=%b addr=%h wd=%h exp 0 1 40 12345678", k, mem_read, mem_write, mem_addr, mem_wdata); end
    end
    tick();
    total++; if ({d_ready, mem_write, mem_read} !== 3'b100) begin bad++;
      $display("FAIL store_ready got dr=%b wr=%b rd=%b exp 1 0 0", d_ready, mem_write, mem_read); end
    total++; if (d_rdata !== 32'hA5A50001) begin bad++;
      $display("FAIL store_rdata_kept got=%h exp=a5a50001", d_rdata); end
    d_req = 0; d_we = 0; mem_rdata = 0;
    tick();
    total++; if ({busy, d_ready} !== 2'b00) begin bad++;
      $display("FAIL store_after got busy=%b dr=%b exp 0 0", busy, d_ready); end
  endtask

  task automatic test_streak();
    int exp_gnt[6] = '{1, 1, 0, 1, 1, 0};
    logic [31:0] exp_addr;
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
    for (int k = 0; k < 6; k++) begin
      exp_addr = (exp_gnt[k] == 1) ? 32'h600 : 32'h500;
      tick();
      total++; if ({grant_id, mem_read, mem_addr} !== {exp_gnt[k][0], 1'b1, exp_addr}) begin bad++;
        $display("FAIL streak_grant%0d got gid=%b rd=%b addr=%h exp gid=%0d rd=1 addr=%h", k, grant_id, mem_read, mem_addr, exp_gnt[k], exp_addr); end
      repeat (L) tick();
      total++; if ({d_ready, if_ready} !== ((exp_gnt[k] == 1) ? 2'b10 : 2'b01)) begin bad++;
        $display("FAIL streak_ready%0d got dr=%b ifr=%b exp owner=%0d", k, d_ready, if_ready, exp_gnt[k]); end
      if (k == 5) begin if_req = 0; d_req = 0; end
      tick();
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL streak_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFE0001;
    tick();
    tick();
    total++; if (mem_write !== 1'b1) begin bad++;
      $display("FAIL rmid_write_before got=%b exp=1", mem_write); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({mem_write, mem_read, busy, d_ready, if_ready, grant_id} !== 6'b0) begin bad++;
      $display("FAIL rmid_drop got wr=%b rd=%b busy=%b dr=%b ifr=%b gid=%b exp all 0", mem_write, mem_read, busy, d_ready, if_ready, grant_id); end
    total++; if ({mem_addr, mem_wdata, d_rdata, if_rdata} !== 128'h0) begin bad++;
      $display("FAIL rmid_data got addr=%h wd=%h d=%h if=%h exp 0", mem_addr, mem_wdata, d_rdata, if_rdata); end
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({busy, mem_read, mem_write, if_ready, d_ready, grant_id, mem_addr, mem_wdata, if_rdata, d_rdata} !== 134'h0) begin bad++;
        $display("FAIL rmid_quiet%0d got busy=%b wr=%b dr=%b addr=%h exp all 0", k, busy, mem_write, d_ready, mem_addr); end
    end
  endtask

  task automatic test_random();
    bit          acc_v, a_port, a_we, r_if, r_d, m_gid, win_d;
    bit          e_rd, e_wr, e_ifr, e_dr, e_busy;
    int          a_start, a_end, a_rdy, streak;
    logic [31:0] a_addr, a_wdata, a_cap, m_if_rd, m_d_rd, rd_now;
    acc_v = 0; a_port = 0; a_we = 0; r_if = 0; r_d = 0; m_gid = 0; streak = 0;
    a_start = 0; a_end = 0; a_rdy = 0;
    a_addr = 0; a_wdata = 0; a_cap = 0; m_if_rd = 0; m_d_rd = 0;
    for (int c = 0; c < 400; c++) begin
      if (acc_v && c == a_rdy && !a_we) begin
        if (a_port) m_d_rd = a_cap;
        else        m_if_rd = a_cap;
      end
      e_rd   = acc_v && c >= a_start && c <= a_end && !a_we;
      e_wr   = acc_v && c >= a_start && c <= a_end && a_we;
      e_ifr  = acc_v && c == a_rdy && !a_port;
      e_dr   = acc_v && c == a_rdy && a_port;
      e_busy = acc_v && c >= a_start && c <= a_rdy;
      total++; if ({mem_read, mem_write} !== {e_rd, e_wr}) begin bad++;
        $display("FAIL rnd_strobe c=%0d got rd=%b wr=%b exp rd=%b wr=%b", c, mem_read, mem_write, e_rd, e_wr); end
      total++; if ({if_ready, d_ready, busy} !== {e_ifr, e_dr, e_busy}) begin bad++;
        $display("FAIL rnd_ready c=%0d got ifr=%b dr=%b busy=%b exp %b %b %b", c, if_ready, d_ready, busy, e_ifr, e_dr, e_busy); end
      total++; if (grant_id !== m_gid) begin bad++;
        $display("FAIL rnd_gid c=%0d got=%b exp=%b", c, grant_id, m_gid); end
      total++; if ({if_rdata, d_rdata} !== {m_if_rd, m_d_rd}) begin bad++;
        $display("FAIL rnd_rdata c=%0d got if=%h d=%h exp if=%h d=%h", c, if_rdata, d_rdata, m_if_rd, m_d_rd); end
      if (e_rd || e_wr) begin
        total++; if (mem_addr !== a_addr) begin bad++;
          $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, a_addr); end
      end
      if (e_wr) begin
        total++; if (mem_wdata !== a_wdata) begin bad++;
          $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, a_wdata); end
      end
      rd_now = $urandom;
      mem_rdata = rd_now;
      if (acc_v && c == a_end) a_cap = rd_now;
      if (acc_v && c == a_rdy + 1) begin
        if (a_port) r_d = 0;
        else        r_if = 0;
      end
      if (!r_if && $urandom_range(0, 2) != 0) begin
        r_if = 1; if_addr = $urandom;
      end
      if (!r_d && $urandom_range(0, 2) != 0) begin
        r_d = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = r_if;
      d_req  = r_d;
      if ((!acc_v || c > a_rdy) && (r_if || r_d)) begin
        win_d = r_d && !(r_if && streak == MAXS);
        if (win_d && r_if) streak = (streak < MAXS) ? streak + 1 : MAXS;
        else               streak = 0;
        acc_v   = 1;
        a_start = c + 1;
        a_end   = c + L;
        a_rdy   = c + L + 1;
        a_port  = win_d;
        a_we    = win_d ? d_we : 1'b0;
        a_addr  = win_d ? d_addr : if_addr;
        a_wdata = d_wdata;
        m_gid   = win_d;
      end
      tick();
    end
    if_req = 0; d_req = 0; d_we = 0;
    repeat (L + 3) tick();
  endtask

  task automatic test_lat1();
    l1_d_req = 1; l1_d_we = 0; l1_d_addr = 32'h44; l1_mem_rdata = 0;
    tick();
    l1_mem_rdata = 32'h11112222;
    total++; if ({l1_mem_read, l1_mem_write, l1_mem_addr, l1_busy} !== {1'b1, 1'b0, 32'h44, 1'b1}) begin bad++;
      $display("FAIL lat1_access got rd=%b wr=%b addr=%h busy=%b exp 1 0 44 1", l1_mem_read, l1_mem_write, l1_mem_addr, l1_busy); end
    tick();
    l1_mem_rdata = 0;
    total++; if ({l1_d_ready, l1_if_ready, l1_mem_read} !== 3'b100) begin bad++;
      $display("FAIL lat1_ready got dr=%b ifr=%b rd=%b exp 1 0 0", l1_d_ready, l1_if_ready, l1_mem_read); end
    total++; if (l1_d_rdata !== 32'h11112222) begin bad++;
      $display("FAIL lat1_rdata got=%h exp=11112222", l1_d_rdata); end
    l1_d_req = 0;
    tick();
    total++; if ({l1_d_ready, l1_busy} !== 2'b00) begin bad++;
      $display("FAIL lat1_after got dr=%b busy=%b exp 0 0", l1_d_ready, l1_busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_streak();
    test_reset_mid();
    test_random();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
